regfile_bank: RTL and testbench
===============================

# regfile_bank

Parametrised multi-port register bank for the next-generation RISC-V core, replacing the fixed 32×32, two-read, one-write register file. Adds a second write port, configurable read-port count, optional write-to-read bypass, a pending-write scoreboard for hazard detection, and a sequential clear engine so the storage array can be inferred as RAM.

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of registers; power of two, ≥ 4.
- AW, $clog2(NREG), address width (derived).
- NRD, 2, number of read ports, 1–4.
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never marked pending.
- BYPASS, 1, 1: same-cycle write data forwarded to reads.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- ready  out  1  0 while clear engine runs; 1 in RUN.
- we0  in  1  write enable, port 0.
- wa0  in  AW  write address, port 0.
- wd0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (priority port).
- wa1  in  AW  write address, port 1.
- wd1  in  XLEN  write data, port 1.
- ra  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
- rd  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN].
- rd_pending  out  NRD  1: register addressed by port i has an outstanding producer.
- sb_set  in  1  mark sb_addr pending.
- sb_addr  in  AW  scoreboard set address.

## Operation
- States: CLEAR, RUN. reset asserted → CLEAR, clear index = 0, ready = 0, all pending bits = 0 (asynchronous).
- CLEAR: each rising edge with reset low writes 0 to entry[clear index], index increments; after entry NREG-1 is written, next state RUN. we0/we1/sb_set ignored; all rd = 0, rd_pending = 0.
- reset reasserted mid-CLEAR or mid-RUN: restart CLEAR from index 0; in-flight writes in that cycle discarded.
- RUN writes: we0 → entry[wa0] = wd0; we1 → entry[wa1] = wd1. Both enabled, same address: port 1 value stored. ZERO_REG=1 and address 0: write dropped.
- RUN reads (combinational): rd[i] = entry[ra[i]]; ZERO_REG=1 and ra[i]=0 → 0. BYPASS=1: if we1 and wa1==ra[i] → wd1; else if we0 and wa0==ra[i] → wd0; else array (zero rule takes precedence over bypass).
- Scoreboard: one pending bit per register. Write on either port to address a clears bit a at the edge; sb_set sets bit sb_addr. Set and clear to same address in same cycle: set wins (newer producer). ZERO_REG=1: sb_set to 0 ignored.
- rd_pending[i] = pending[ra[i]]; BYPASS=1: forced 0 when a write to ra[i] is present this cycle (data already forwarded).

## Timing
- Reset values: ready 0, rd all 0, rd_pending all 0.
- Clear latency: reset deasserted before edge 1 → entries 0..NREG-1 zeroed on edges 1..NREG; ready = 1 after edge NREG (NREG=32: ready high after 32nd edge).
- Write latency: data visible on array read the cycle after the edge; with BYPASS=1, visible same cycle combinationally.
- Read latency: zero cycles (asynchronous read).
- Scoreboard: sb_set at edge n → rd_pending visible after edge n; clearing write at edge m → pending low after edge m (BYPASS=1: already low during cycle m).
- No handshake on write ports; ready is status only. Writes issued while ready=0 are lost.

## Test plan
- Reset then idle, NREG=32: ready 0 for 32 edges, 1 after edge 32; every ra returns 0x00000000; write x5=0xDEADBEEF, next cycle ra0=5 → 0xDEADBEEF.
- Dual write conflict: we0/we1 both to x7, wd0=0x11111111, wd1=0x22222222 → x7 = 0x22222222; same with wa0=3, wa1=4 → both stored.
- Zero register: we1 to x0 with 0xFFFFFFFF and sb_set to x0 → ra=0 reads 0, rd_pending 0; ZERO_REG=0 build → reads 0xFFFFFFFF.
- Bypass: BYPASS=1, x9=0xA, write 0xB to x9 same cycle as read → rd=0xB, rd_pending 0; BYPASS=0 → rd=0xA, then 0xB next cycle.
- Scoreboard: sb_set x12 → rd_pending 1 next cycle; write x12 and sb_set x12 same edge → still pending; write x12 alone → pending 0.
- Reset mid-clear at edge 10 and mid-run: ready drops immediately, pending bits 0, full 32-edge clear repeats, previously written x5 reads 0 afterward.

Source files
------------

// File: rtl/regfile_bank.sv
// ============================================================================
// Module   : regfile_bank
// Brief    : Multi-port register bank with dual write ports, optional
//            write-to-read bypass, pending-write scoreboard and clear engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_bank #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                we0,
    input  logic [AW-1:0]       wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [AW-1:0]       wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_pending,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam bit            HAS_ZERO = (ZERO_REG != 0);
    localparam bit            HAS_BYP  = (BYPASS != 0);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_clr_idx;
    logic [AW-1:0]   w_clr_idx_nxt;
    logic [XLEN-1:0] r_mem [NREG];
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_pending_nxt;

    logic w_run;
    logic w_we0;
    logic w_we1;
    logic w_sb_set;

    assign w_run    = (r_state == ST_RUN);
    assign w_we0    = w_run && we0 && !(HAS_ZERO && (wa0 == '0));
    assign w_we1    = w_run && we1 && !(HAS_ZERO && (wa1 == '0));
    assign w_sb_set = w_run && sb_set && !(HAS_ZERO && (sb_addr == '0));
    assign ready    = w_run;

    // ------------------------------------------------------------------
    // Control state machine: CLEAR walks every entry once, then RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            ST_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_clr_idx_nxt = '0;
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array: no reset so it maps onto RAM; port 1 is written last
    // so it wins an address collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_idx] <= '0;
            end else begin
                if (w_we0) begin
                    r_mem[wa0] <= wd0;
                end
                if (w_we1) begin
                    r_mem[wa1] <= wd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: writes retire a producer, sb_set applied last so a new
    // producer issued in the same cycle keeps the bit set.
    // ------------------------------------------------------------------
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_we0) begin
            w_pending_nxt[wa0] = 1'b0;
        end
        if (w_we1) begin
            w_pending_nxt[wa1] = 1'b0;
        end
        if (w_sb_set) begin
            w_pending_nxt[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic            w_zero;
        logic            w_hit0;
        logic            w_hit1;
        logic [XLEN-1:0] w_data;

        assign w_ra   = ra[i*AW +: AW];
        assign w_zero = HAS_ZERO && (w_ra == '0);
        assign w_hit0 = HAS_BYP && w_we0 && (wa0 == w_ra);
        assign w_hit1 = HAS_BYP && w_we1 && (wa1 == w_ra);

        // Zero register outranks forwarding; port 1 outranks port 0.
        always_comb begin
            w_data = '0;
            if (w_run && !w_zero) begin
                if (w_hit1) begin
                    w_data = wd1;
                end else if (w_hit0) begin
                    w_data = wd0;
                end else begin
                    w_data = r_mem[w_ra];
                end
            end
        end

        assign rd[i*XLEN +: XLEN] = w_data;
        assign rd_pending[i]      = w_run && r_pending[w_ra] && !w_hit0 && !w_hit1;
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_bank.sv
// ============================================================================
// Module   : tb_regfile_bank
// Brief    : Directed self-checking bench; a default build and a build with
//            ZERO_REG=0 / BYPASS=0 share one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_bank;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                we0, we1, sb_set;
    logic [AW-1:0]       wa0, wa1, sb_addr;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NRD*AW-1:0]   ra;

    logic                ready,   ready_a;
    logic [NRD*XLEN-1:0] rd,      rd_a;
    logic [NRD-1:0]      pend,    pend_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_bank #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd), .rd_pending(pend),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    regfile_bank #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(0), .BYPASS(0)
    ) dut_alt (
        .clk(clk), .reset(reset), .ready(ready_a),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra(ra), .rd(rd_a), .rd_pending(pend_a),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        sb_set = 1'b0; sb_addr = '0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    // Counts 32 clear edges from deasserted reset; ready must rise only on the last.
    task automatic run_clear(input string tag);
        for (int k = 1; k <= NREG; k++) begin
            step();
            if (k == 5)  chk({tag, "_rd_during_clear"}, rd[XLEN-1:0], 32'h0);
            if (k == 31) chk({tag, "_ready_edge31"}, 32'(ready), 32'h0);
            if (k == 32) chk({tag, "_ready_edge32"}, 32'(ready), 32'h1);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        set_ra(5'd5, 5'd0);
        step(); step();
        chk("reset_ready",   32'(ready),        32'h0);
        chk("reset_rd0",     rd[31:0],          32'h0);
        chk("reset_rd1",     rd[63:32],         32'h0);
        chk("reset_pending", 32'(pend),         32'h0);

        // Clear from reset; a write held during clear must be lost.
        reset = 1'b0;
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h55555555;
        run_clear("clr1");
        idle_inputs();
        #1;
        chk("write_lost_in_clear", rd[31:0], 32'h0);
        for (int i = 0; i < NREG; i += 7) begin
            set_ra(AW'(i), AW'(NREG - 1 - i));
            #1;
            chk("cleared_rd0", rd[31:0],  32'h0);
            chk("cleared_rd1", rd[63:32], 32'h0);
        end

        // Basic write then read next cycle.
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
        set_ra(5'd6, 5'd6);
        step();
        idle_inputs();
        set_ra(5'd5, 5'd6);
        #1;
        chk("x5_read",     rd[31:0],   32'hDEADBEEF);
        chk("x5_read_alt", rd_a[31:0], 32'hDEADBEEF);

        // Dual write to the same address: port 1 wins.
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
        set_ra(5'd1, 5'd1);
        step();
        idle_inputs();
        set_ra(5'd7, 5'd7);
        #1;
        chk("conflict_x7",     rd[31:0],   32'h22222222);
        chk("conflict_x7_alt", rd_a[31:0], 32'h22222222);

        // Dual write to distinct addresses.
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33333333;
        we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h44444444;
        set_ra(5'd1, 5'd1);
        step();
        idle_inputs();
        set_ra(5'd3, 5'd4);
        #1;
        chk("dual_x3", rd[31:0],  32'h33333333);
        chk("dual_x4", rd[63:32], 32'h44444444);

        // Zero register: write and sb_set to x0.
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        set_ra(5'd0, 5'd0);
        #1;
        chk("zero_bypass_rd", rd[31:0], 32'h0);
        step();
        idle_inputs();
        #1;
        chk("zero_rd",          rd[31:0],    32'h0);
        chk("zero_pending",     32'(pend[0]), 32'h0);
        chk("nozero_rd_alt",    rd_a[31:0],  32'hFFFFFFFF);
        chk("nozero_pend_alt",  32'(pend_a[0]), 32'h1);

        // Bypass: x9=0xA with a new producer marked, then write 0xB while reading.
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000000A;
        sb_set = 1'b1; sb_addr = 5'd9;
        set_ra(5'd1, 5'd1);
        step();
        idle_inputs();
        set_ra(5'd9, 5'd1);
        #1;
        chk("x9_pending", 32'(pend[0]), 32'h1);
        we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0000000B;
        #1;
        chk("bypass_rd",       rd[31:0],      32'h0000000B);
        chk("bypass_pend",     32'(pend[0]),  32'h0);
        chk("nobypass_rd",     rd_a[31:0],    32'h0000000A);
        chk("nobypass_pend",   32'(pend_a[0]), 32'h1);
        step();
        idle_inputs();
        #1;
        chk("nobypass_rd_next",   rd_a[31:0],     32'h0000000B);
        chk("nobypass_pend_next", 32'(pend_a[0]), 32'h0);

        // Scoreboard on x12 via read port 1.
        sb_set = 1'b1; sb_addr = 5'd12;
        set_ra(5'd1, 5'd12);
        #1;
        chk("sb_before_edge", 32'(pend[1]), 32'h0);
        step();
        idle_inputs();
        #1;
        chk("sb_set_x12",     32'(pend[1]),   32'h1);
        chk("sb_set_x12_alt", 32'(pend_a[1]), 32'h1);
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h12121212;
        sb_set = 1'b1; sb_addr = 5'd12;
        #1;
        chk("sb_fwd_forced0", 32'(pend[1]),   32'h0);
        chk("sb_nofwd_held",  32'(pend_a[1]), 32'h1);
        step();
        idle_inputs();
        #1;
        chk("sb_set_wins",     32'(pend[1]),   32'h1);
        chk("sb_set_wins_alt", 32'(pend_a[1]), 32'h1);
        we1 = 1'b1; wa1 = 5'd12; wd1 = 32'h12121213;
        step();
        idle_inputs();
        #1;
        chk("sb_cleared",     32'(pend[1]),   32'h0);
        chk("sb_cleared_alt", 32'(pend_a[1]), 32'h0);
        chk("x12_data",       rd[63:32],      32'h12121213);

        // Mid-run reset with a pending x20 and an in-flight write.
        sb_set = 1'b1; sb_addr = 5'd20;
        step();
        idle_inputs();
        set_ra(5'd5, 5'd20);
        #1;
        chk("x20_pending", 32'(pend[1]), 32'h1);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h77777777;
        reset = 1'b1;
        #1;
        chk("midrun_ready",   32'(ready), 32'h0);
        chk("midrun_pending", 32'(pend),  32'h0);
        chk("midrun_rd",      rd[31:0],   32'h0);
        step();
        idle_inputs();
        reset = 1'b0;

        // Abort the clear after 10 edges; the full clear must restart.
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1;
        #1;
        chk("midclear_ready", 32'(ready), 32'h0);
        step();
        reset = 1'b0;
        run_clear("clr2");
        #1;
        chk("x5_after_reset",   rd[31:0],     32'h0);
        chk("x20_pend_after",   32'(pend[1]), 32'h0);
        chk("x5_after_alt",     rd_a[31:0],   32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
